hazard_sched: RTL and testbench
===============================

HAZARD_SCHED -- requirements
Module: hazard_sched

Interface
REQ-001 SHALL have parameter CNT_W, default 32, the width of each performance counter.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports rs1use_ID, rs2use_ID  input  1  the ID-stage instruction reads rs1 / rs2.
REQ-005 SHALL have ports rs1_ID, rs2_ID, rd_ID  input  5  register indices of the ID-stage instruction.
REQ-006 SHALL have port hazard_optype_ID  input  2  the ID-stage class: 00 none, 01 ALU, 10 load, 11 store.
REQ-007 SHALL have port Branch_ID  input  1  the ID stage redirects the PC this cycle (taken branch, JAL, JALR).
REQ-008 SHALL have ports forward_ctrl_A, forward_ctrl_B  output  2  ID operand source: 00 regfile, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data.
REQ-009 SHALL have port forward_ctrl_ls  output  1  the EX-stage store data is taken from the MEM load data.
REQ-010 SHALL have ports PC_EN_IF, reg_FD_EN  output  1  the enables for the PC and the IF/ID register.
REQ-011 SHALL have ports reg_FD_flush, reg_DE_flush  output  1  insert a bubble into IF/ID or ID/EX.
REQ-012 SHALL have ports stall_cnt, flush_cnt  output  CNT_W  the performance counters.

Function
REQ-013 SHALL hold three internal slots, EX, MEM and WB; each slot holds {optype[1:0], rd[4:0], rs2[4:0]}.
REQ-014 SHALL update the slots every cycle: WB<=MEM, MEM<=EX, and EX<=ID inputs, or EX<=bubble (all zero) when stall=1.
REQ-015 SHALL define a match as a source index equal to a slot rd, with the index nonzero and the slot optype 01 or 10; a store or none slot never matches.
REQ-016 SHALL assert stall when the EX slot is a load, rs1use_ID=1 and rs1_ID matches EX.rd.
REQ-017 SHALL also assert stall when the EX slot is a load, rs2use_ID=1, rs2_ID matches EX.rd, and hazard_optype_ID is not 11; in that case the store data is forwarded later through forward_ctrl_ls.
REQ-018 SHALL drive PC_EN_IF = reg_FD_EN = ~stall, and reg_DE_flush = stall.
REQ-019 SHALL drive reg_FD_flush = Branch_ID & ~stall; when a stall and a branch occur together the stall wins, because the branch operand is not yet valid.
REQ-020 SHALL select forward_ctrl_A with this priority: an EX ALU match gives 01; otherwise a MEM ALU match gives 10; otherwise a MEM load match gives 11; otherwise 00.
REQ-021 SHALL select forward_ctrl_B by the same rule using rs2_ID.
REQ-022 SHALL gate forwarding with rsNuse_ID: when rsNuse_ID=0 the corresponding select is 00.
REQ-023 SHALL ignore the WB slot for forwarding, because the register file writes first and reads second.
REQ-024 SHALL drive forward_ctrl_ls = 1 when EX.optype=11, MEM.optype=10, EX.rs2 = MEM.rd, and MEM.rd is nonzero.
REQ-025 SHALL make all outputs except the counters combinational from the slots and the inputs, with zero latency.
REQ-026 SHALL increment stall_cnt in every cycle in which stall=1.
REQ-027 SHALL increment flush_cnt in every cycle in which reg_FD_flush=1.
REQ-028 SHALL saturate both counters at all-ones; they never wrap.

Reset
REQ-029 SHALL, while rst=1, asynchronously clear all slots to bubble and both counters to 0.
REQ-030 SHALL, after reset with all inputs 0, output PC_EN_IF=1, reg_FD_EN=1, both flushes 0, and all forward selects 0.
REQ-031 SHALL have no state other than the slots and the counters, so a reset in mid-stall leaves nothing pending.

Verification
REQ-032 The bench SHALL cover ALU chain: cycle0 ID ALU with rd=5, then cycle1 ID rs1use=1, rs1=5 -> forward_ctrl_A=01, no stall; with one unrelated instruction in between -> 10.
REQ-033 The bench SHALL cover load-use: ID load with rd=7, then ID ALU rs2use=1, rs2=7 -> stall exactly 1 cycle (PC_EN_IF=0, reg_DE_flush=1, stall_cnt+1), then forward_ctrl_B=11.
REQ-034 The bench SHALL cover load then store of rs2: load rd=7, then store rs2=7 -> no stall; one cycle later forward_ctrl_ls=1.
REQ-035 The bench SHALL cover the x0 case and priority: load rd=0 then rs1=0 -> no stall and select 00; ALU rd=3 twice in a row then rs1=3 -> 01 (EX wins).
REQ-036 The bench SHALL cover branch against stall: Branch_ID=1 during a load-use stall -> reg_FD_flush=0; next cycle Branch_ID=1 -> reg_FD_flush=1 and flush_cnt+1.
REQ-037 The bench SHALL cover reset and saturation: assert rst in mid-stall -> outputs at once equal the REQ-030 values; with CNT_W=2, 5 stalls -> stall_cnt=3.

Source files
------------

// File: rtl/hazard_if.sv
// Hazard scheduler bundle: ID-stage instruction descriptor in, forward/stall/flush controls and counters out.
// The master side is the pipeline driving ID info; the slave side is the scheduler.
interface hazard_if #(parameter int CNT_W = 32);
  logic             rs1use_ID, rs2use_ID;
  logic [4:0]       rs1_ID, rs2_ID, rd_ID;
  logic [1:0]       hazard_optype_ID;
  logic             Branch_ID;
  logic [1:0]       forward_ctrl_A, forward_ctrl_B;
  logic             forward_ctrl_ls;
  logic             PC_EN_IF, reg_FD_EN;
  logic             reg_FD_flush, reg_DE_flush;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output rs1use_ID, rs2use_ID, rs1_ID, rs2_ID, rd_ID, hazard_optype_ID, Branch_ID,
    input  forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls, PC_EN_IF, reg_FD_EN,
           reg_FD_flush, reg_DE_flush, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1use_ID, rs2use_ID, rs1_ID, rs2_ID, rd_ID, hazard_optype_ID, Branch_ID,
    output forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls, PC_EN_IF, reg_FD_EN,
           reg_FD_flush, reg_DE_flush, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_sched.sv
// Five-stage pipeline hazard scheduler: tracks EX/MEM/WB descriptors, picks forward sources,
// stalls one cycle on load-use, and counts stall and flush cycles with saturating counters.
module hazard_sched #(
  parameter int CNT_W = 32
) (
  input  logic    clk,
  input  logic    rst,
  hazard_if.slave hif
);
  localparam logic [1:0] OP_ALU = 2'b01;
  localparam logic [1:0] OP_LD  = 2'b10;
  localparam logic [1:0] OP_ST  = 2'b11;
  localparam int EX  = 0;
  localparam int MEM = 1;
  localparam int WB  = 2;

  typedef struct packed {
    logic [1:0] optype;
    logic [4:0] rd;
    logic [4:0] rs2;
  } slot_t;

  slot_t            slot [3];
  logic             stall;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  // Only slots that write the register file can supply a value; x0 never does.
  function automatic logic hit(input slot_t s, input logic [4:0] idx);
    return (idx != 5'd0) && (idx == s.rd) && (s.optype == OP_ALU || s.optype == OP_LD);
  endfunction

  function automatic logic [1:0] fsel(input logic use_src, input logic [4:0] idx,
                                      input slot_t ex_s, input slot_t mem_s);
    if (!use_src)                               return 2'b00;
    if (hit(ex_s, idx)  && ex_s.optype  == OP_ALU) return 2'b01;
    if (hit(mem_s, idx) && mem_s.optype == OP_ALU) return 2'b10;
    if (hit(mem_s, idx) && mem_s.optype == OP_LD)  return 2'b11;
    return 2'b00;
  endfunction

  // A store's rs2 behind a load is not a stall: the data is patched in EX from MEM.
  assign stall = (slot[EX].optype == OP_LD) &&
                 ((hif.rs1use_ID && hit(slot[EX], hif.rs1_ID)) ||
                  (hif.rs2use_ID && hit(slot[EX], hif.rs2_ID) && hif.hazard_optype_ID != OP_ST));

  assign hif.PC_EN_IF        = ~stall;
  assign hif.reg_FD_EN       = ~stall;
  assign hif.reg_DE_flush    = stall;
  assign hif.reg_FD_flush    = hif.Branch_ID & ~stall;
  assign hif.forward_ctrl_A  = fsel(hif.rs1use_ID, hif.rs1_ID, slot[EX], slot[MEM]);
  assign hif.forward_ctrl_B  = fsel(hif.rs2use_ID, hif.rs2_ID, slot[EX], slot[MEM]);
  assign hif.forward_ctrl_ls = (slot[EX].optype == OP_ST) && (slot[MEM].optype == OP_LD) &&
                               (slot[EX].rs2 == slot[MEM].rd) && (slot[MEM].rd != 5'd0);
  assign hif.stall_cnt       = stall_cnt;
  assign hif.flush_cnt       = flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) slot[i] <= '0;
    end else begin
      slot[WB]  <= slot[MEM];
      slot[MEM] <= slot[EX];
      slot[EX]  <= stall ? '0 : slot_t'{hif.hazard_optype_ID, hif.rd_ID, hif.rs2_ID};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && !(&stall_cnt))            stall_cnt <= stall_cnt + CNT_W'(1);
      if (hif.reg_FD_flush && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched: a vector table walked cycle by cycle, then reset-in-stall
// and counter saturation sequences against a 2-bit-counter instance.
module tb_hazard_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_if #(.CNT_W(32)) hif ();
  hazard_if #(.CNT_W(2))  hif2 ();

  hazard_sched #(.CNT_W(32)) dut  (.clk(clk), .rst(rst), .hif(hif));
  hazard_sched #(.CNT_W(2))  dut2 (.clk(clk), .rst(rst), .hif(hif2));

  assign hif2.rs1use_ID        = hif.rs1use_ID;
  assign hif2.rs2use_ID        = hif.rs2use_ID;
  assign hif2.rs1_ID           = hif.rs1_ID;
  assign hif2.rs2_ID           = hif.rs2_ID;
  assign hif2.rd_ID            = hif.rd_ID;
  assign hif2.hazard_optype_ID = hif.hazard_optype_ID;
  assign hif2.Branch_ID        = hif.Branch_ID;

  typedef struct {
    string      nm;
    logic       r1u, r2u;
    logic [4:0] r1, r2, rd;
    logic [1:0] op;
    logic       br;
    logic [1:0] fa, fb;
    logic       ls, st, fl;
    int         sc, fc;
  } vec_t;

  vec_t tv[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(string nm, logic r1u, logic [4:0] r1, logic r2u, logic [4:0] r2,
                              logic [4:0] rd, logic [1:0] op, logic br,
                              logic [1:0] fa, logic [1:0] fb, logic ls, logic st, logic fl,
                              int sc, int fc);
    vec_t v;
    v.nm = nm; v.r1u = r1u; v.r1 = r1; v.r2u = r2u; v.r2 = r2; v.rd = rd; v.op = op; v.br = br;
    v.fa = fa; v.fb = fb; v.ls = ls; v.st = st; v.fl = fl; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r1u, input logic [4:0] r1, input logic r2u, input logic [4:0] r2,
                       input logic [4:0] rd, input logic [1:0] op, input logic br);
    hif.rs1use_ID = r1u; hif.rs1_ID = r1;
    hif.rs2use_ID = r2u; hif.rs2_ID = r2;
    hif.rd_ID = rd; hif.hazard_optype_ID = op; hif.Branch_ID = br;
  endtask

  // {fa, fb, ls, PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush}
  function automatic logic [9:0] outs();
    return {hif.forward_ctrl_A, hif.forward_ctrl_B, hif.forward_ctrl_ls, hif.PC_EN_IF,
            hif.reg_FD_EN, hif.reg_FD_flush, hif.reg_DE_flush};
  endfunction

  localparam logic [9:0] IDLE_OUTS = 10'b00_00_0_1_1_0_0;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // name               r1u r1  r2u r2  rd  op    br   fa     fb     ls st fl sc fc
    tv.push_back(mk("reset_idle",  0, 0, 0, 0, 0, 2'd0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    tv.push_back(mk("alu_rd5",     0, 0, 0, 0, 5, 2'd1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    tv.push_back(mk("fwdA_ex",     1, 5, 0, 0, 6, 2'd1, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0));
    tv.push_back(mk("alu_rd5_b",   0, 0, 0, 0, 5, 2'd1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    tv.push_back(mk("unrelated",   0, 0, 0, 0, 9, 2'd1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    tv.push_back(mk("fwdA_mem",    1, 5, 0, 0, 0, 2'd1, 0, 2'b10, 2'b00, 0, 0, 0, 0, 0));
    tv.push_back(mk("load_rd7",    0, 0, 0, 0, 7, 2'd2, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    tv.push_back(mk("ld_use_stl",  0, 0, 1, 7, 8, 2'd1, 0, 2'b00, 2'b00, 0, 1, 0, 0, 0));
    tv.push_back(mk("ld_use_fwd",  0, 0, 1, 7, 8, 2'd1, 0, 2'b00, 2'b11, 0, 0, 0, 1, 0));
    tv.push_back(mk("load_rd7_b",  0, 0, 0, 0, 7, 2'd2, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0));
    tv.push_back(mk("st_no_stall", 0, 0, 1, 7, 0, 2'd3, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0));
    tv.push_back(mk("st_fwd_ls",   0, 0, 0, 0, 0, 2'd0, 0, 2'b00, 2'b00, 1, 0, 0, 1, 0));
    tv.push_back(mk("load_rd0",    0, 0, 0, 0, 0, 2'd2, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0));
    tv.push_back(mk("x0_no_stall", 1, 0, 0, 0, 0, 2'd1, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0));
    tv.push_back(mk("alu_rd3_a",   0, 0, 0, 0, 3, 2'd1, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0));
    tv.push_back(mk("alu_rd3_b",   0, 0, 0, 0, 3, 2'd1, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0));
    tv.push_back(mk("ex_wins",     1, 3, 1, 3, 0, 2'd1, 0, 2'b01, 2'b01, 0, 0, 0, 1, 0));
    tv.push_back(mk("load_rd4",    0, 0, 0, 0, 4, 2'd2, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0));
    tv.push_back(mk("br_in_stall", 1, 4, 0, 0, 0, 2'd1, 1, 2'b00, 2'b00, 0, 1, 0, 1, 0));
    tv.push_back(mk("br_flush",    1, 4, 0, 0, 0, 2'd1, 1, 2'b11, 2'b00, 0, 0, 1, 2, 0));
    tv.push_back(mk("after_br",    0, 0, 0, 0, 0, 2'd0, 0, 2'b00, 2'b00, 0, 0, 0, 2, 1));
    tv.push_back(mk("alu_rd12",    0, 0, 0, 0,12, 2'd1, 0, 2'b00, 2'b00, 0, 0, 0, 2, 1));
    tv.push_back(mk("use_gated",   0,12, 0,12, 0, 2'd2, 0, 2'b00, 2'b00, 0, 0, 0, 2, 1));

    drive(0, 0, 0, 0, 0, 2'd0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall_cnt", hif.stall_cnt, 0);
    rst = 1'b0;

    foreach (tv[i]) begin
      drive(tv[i].r1u, tv[i].r1, tv[i].r2u, tv[i].r2, tv[i].rd, tv[i].op, tv[i].br);
      @(negedge clk);
      chk({tv[i].nm, "_outs"}, outs(),
          {tv[i].fa, tv[i].fb, tv[i].ls, ~tv[i].st, ~tv[i].st, tv[i].fl, tv[i].st});
      chk({tv[i].nm, "_stall_cnt"}, hif.stall_cnt, tv[i].sc);
      chk({tv[i].nm, "_flush_cnt"}, hif.flush_cnt, tv[i].fc);
      next_cycle();
    end

    // Reset asserted in the middle of a load-use stall
    drive(0, 0, 0, 0, 7, 2'd2, 0);
    next_cycle();
    drive(1, 7, 0, 0, 1, 2'd1, 0);
    @(negedge clk);
    chk("mid_stall_pc_en", hif.PC_EN_IF, 0);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_outs", outs(), IDLE_OUTS);
    chk("rst_async_stall_cnt", hif.stall_cnt, 0);
    chk("rst_async_flush_cnt", hif.flush_cnt, 0);
    drive(0, 0, 0, 0, 0, 2'd0, 0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_outs", outs(), IDLE_OUTS);
    next_cycle();

    // Five separate load-use stalls; 2-bit counter must stop at 3
    for (int r = 0; r < 5; r++) begin
      drive(0, 0, 0, 0, 7, 2'd2, 0);
      next_cycle();
      drive(1, 7, 0, 0, 1, 2'd1, 0);
      next_cycle();
      if (r == 2) chk("sat_narrow_at3", hif2.stall_cnt, 3);
      if (r == 3) chk("sat_narrow_hold", hif2.stall_cnt, 3);
    end
    drive(0, 0, 0, 0, 0, 2'd0, 0);
    @(negedge clk);
    chk("sat_wide_cnt", hif.stall_cnt, 5);
    chk("sat_narrow_cnt", hif2.stall_cnt, 3);
    chk("sat_narrow_flush", hif2.flush_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
